// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multicycle_control_if #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 2
);
  logic [OPCODE_W-1:0] opcode;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                link;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUOP_W-1:0]  alu_op;
  logic [1:0]          pc_source;
  logic                illegal;
  logic                instr_done;
  logic [3:0]          state_o;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, link, alu_src_a, alu_src_b, alu_op, pc_source, illegal,
           instr_done, state_o
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, link, alu_src_a, alu_src_b, alu_op, pc_source, illegal,
           instr_done, state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory wait states, immediate ALU ops, J/JAL/JR,
// illegal-opcode detection and a per-instruction retire pulse.
module multicycle_control #(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned ALUOP_W     = 2,
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          IMM_EN      = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StImmEx  = 4'd10,
    StImmWb  = 4'd11,
    StJr     = 4'd12
  } state_e;

  localparam logic [OPCODE_W-1:0] OpRType = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OpLw    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OpSw    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OpBeq   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OpJ     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OpJal   = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OpAddi  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OpAndi  = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OpOri   = OPCODE_W'(6'b001101);
  localparam logic [5:0]          FnJr    = 6'b001000;

  state_e state_q, state_d;
  logic   ready;
  logic   pw, pwc, iord, mr, mw, irw, m2r, rd, rw, lk, asa, ill, dn;
  logic [1:0] asb, aop, psrc;

  // The datapath ANDs zero with pc_write_cond itself.
  logic unused_zero;
  assign unused_zero = bus.zero;

  assign ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  always_comb begin
    state_d = StFetch;
    pw = 1'b0; pwc = 1'b0; iord = 1'b0; mr = 1'b0; mw = 1'b0; irw = 1'b0; m2r = 1'b0;
    rd = 1'b0; rw = 1'b0; lk = 1'b0; asa = 1'b0; ill = 1'b0; dn = 1'b0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (state_q)
      StFetch: begin
        mr  = 1'b1;
        asb = 2'b01;
        if (ready) begin
          irw     = 1'b1;
          pw      = 1'b1;
          state_d = StDecode;
        end else begin
          state_d = StFetch;
        end
      end
      StDecode: begin
        asb = 2'b11;
        if (bus.opcode == OpLw || bus.opcode == OpSw) begin
          state_d = StMemAdr;
        end else if (bus.opcode == OpRType) begin
          state_d = (bus.funct == FnJr) ? StJr : StExec;
        end else if (bus.opcode == OpBeq) begin
          state_d = StBranch;
        end else if (bus.opcode == OpJ || bus.opcode == OpJal) begin
          state_d = StJump;
        end else if (IMM_EN && (bus.opcode == OpAddi || bus.opcode == OpAndi ||
                                bus.opcode == OpOri)) begin
          state_d = StImmEx;
        end else begin
          ill = 1'b1;
        end
      end
      StMemAdr: begin
        asa     = 1'b1;
        asb     = 2'b10;
        state_d = (bus.opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mr      = 1'b1;
        iord    = 1'b1;
        state_d = ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        rw  = 1'b1;
        m2r = 1'b1;
        dn  = 1'b1;
      end
      StMemWr: begin
        mw      = 1'b1;
        iord    = 1'b1;
        dn      = ready;
        state_d = ready ? StFetch : StMemWr;
      end
      StExec: begin
        asa     = 1'b1;
        aop     = 2'b10;
        state_d = StRwb;
      end
      StRwb: begin
        rw = 1'b1;
        rd = 1'b1;
        dn = 1'b1;
      end
      StBranch: begin
        asa  = 1'b1;
        aop  = 2'b01;
        pwc  = 1'b1;
        psrc = 2'b01;
        dn   = 1'b1;
      end
      StJump: begin
        pw   = 1'b1;
        psrc = 2'b10;
        dn   = 1'b1;
        if (bus.opcode == OpJal) begin
          rw = 1'b1;
          lk = 1'b1;
        end
      end
      StImmEx: begin
        asa     = 1'b1;
        asb     = 2'b10;
        aop     = (bus.opcode == OpAddi) ? 2'b00 : 2'b11;
        state_d = StImmWb;
      end
      StImmWb: begin
        rw = 1'b1;
        dn = 1'b1;
      end
      StJr: begin
        pw   = 1'b1;
        psrc = 2'b11;
        dn   = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Every output is forced low while reset is held, so an abandoned instruction writes nothing.
  assign bus.pc_write      = pw   & ~reset;
  assign bus.pc_write_cond = pwc  & ~reset;
  assign bus.iord          = iord & ~reset;
  assign bus.mem_read      = mr   & ~reset;
  assign bus.mem_write     = mw   & ~reset;
  assign bus.ir_write      = irw  & ~reset;
  assign bus.mem_to_reg    = m2r  & ~reset;
  assign bus.reg_dst       = rd   & ~reset;
  assign bus.reg_write     = rw   & ~reset;
  assign bus.link          = lk   & ~reset;
  assign bus.alu_src_a     = asa  & ~reset;
  assign bus.illegal       = ill  & ~reset;
  assign bus.instr_done    = dn   & ~reset;
  assign bus.alu_src_b     = asb  & {2{~reset}};
  assign bus.pc_source     = psrc & {2{~reset}};
  assign bus.alu_op        = ALUOP_W'(aop) & {ALUOP_W{~reset}};
  assign bus.state_o       = state_q & {4{~reset}};
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: expected state walk per instruction is derived from instruction class
// and chosen wait counts; per-state strobes come from the control table.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic [5:0] op, fn;
  logic       rdy;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.OPCODE_W(6), .ALUOP_W(2)) if0 ();
  multicycle_control_if #(.OPCODE_W(6), .ALUOP_W(2)) if1 ();

  logic rst0, rst1;
  assign rst0 = rst | sel;
  assign rst1 = rst | ~sel;

  assign if0.opcode = op;  assign if0.funct = fn;  assign if0.zero = 1'b0;
  assign if0.mem_ready = rdy;
  assign if1.opcode = op;  assign if1.funct = fn;  assign if1.zero = 1'b0;
  assign if1.mem_ready = rdy;

  multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .MEM_WAIT_EN(1'b1), .IMM_EN(1'b1)) dut0 (
    .clk(clk), .reset(rst0), .bus(if0.master)
  );
  multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .MEM_WAIT_EN(1'b0), .IMM_EN(1'b0)) dut1 (
    .clk(clk), .reset(rst1), .bus(if1.master)
  );

  logic [18:0] obs0, obs1, obs;
  logic [3:0]  st;
  assign obs0 = {if0.pc_write, if0.pc_write_cond, if0.iord, if0.mem_read, if0.mem_write,
                 if0.ir_write, if0.mem_to_reg, if0.reg_dst, if0.reg_write, if0.link,
                 if0.alu_src_a, if0.alu_src_b, if0.alu_op, if0.pc_source, if0.illegal,
                 if0.instr_done};
  assign obs1 = {if1.pc_write, if1.pc_write_cond, if1.iord, if1.mem_read, if1.mem_write,
                 if1.ir_write, if1.mem_to_reg, if1.reg_dst, if1.reg_write, if1.link,
                 if1.alu_src_a, if1.alu_src_b, if1.alu_op, if1.pc_source, if1.illegal,
                 if1.instr_done};
  assign obs = sel ? obs1 : obs0;
  assign st  = sel ? if1.state_o : if0.state_o;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, FJR = 6'b001000;

  function automatic bit is_imm(input logic [5:0] o);
    return o == ADDI || o == ANDI || o == ORI;
  endfunction

  function automatic bit is_legal(input logic [5:0] o, input bit im);
    return o == LW || o == SW || o == RT || o == BEQ || o == J || o == JAL ||
           (im && is_imm(o));
  endfunction

  // Control strobes each state must present, straight from the control table.
  function automatic logic [18:0] exp_out(input int s, input logic r, input logic [5:0] o,
                                          input bit im);
    logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, lk, asa, ill, dn;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, io, mr, mw, irw, m2r, rd, rw, lk, asa, ill, dn} = '0;
    asb = 2'd0; aop = 2'd0; psrc = 2'd0;
    case (s)
      0:  begin mr = 1; asb = 2'd1; irw = r; pw = r; end
      1:  begin asb = 2'd3; ill = !is_legal(o, im); end
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; io = 1; dn = r; end
      6:  begin asa = 1; aop = 2'd2; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; dn = 1; end
      9:  begin pw = 1; psrc = 2'd2; dn = 1; rw = (o == JAL); lk = (o == JAL); end
      10: begin asa = 1; asb = 2'd2; aop = (o == ADDI) ? 2'd0 : 2'd3; end
      11: begin rw = 1; dn = 1; end
      12: begin pw = 1; psrc = 2'd3; dn = 1; end
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, lk, asa, asb, aop, psrc, ill, dn};
  endfunction

  // Runs one instruction starting in FETCH; wm_in < 0 picks a random memory wait count.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int wm_in);
    int sq[$];
    bit rq[$];
    int wf, wm;
    bit we, im;
    logic eff;
    we = (sel == 1'b0);
    im = (sel == 1'b0);
    wf = we ? int'($urandom_range(0, 2)) : 0;
    wm = !we ? 0 : ((wm_in < 0) ? int'($urandom_range(0, 3)) : wm_in);
    op = o;
    fn = f;
    for (int i = 0; i < wf; i++) begin sq.push_back(0); rq.push_back(1'b0); end
    sq.push_back(0); rq.push_back(we ? 1'b1 : 1'($urandom));
    sq.push_back(1); rq.push_back(1'($urandom));
    if (o == LW || o == SW) begin
      sq.push_back(2); rq.push_back(1'($urandom));
      for (int i = 0; i < wm; i++) begin
        sq.push_back(o == LW ? 3 : 5); rq.push_back(1'b0);
      end
      sq.push_back(o == LW ? 3 : 5); rq.push_back(we ? 1'b1 : 1'($urandom));
      if (o == LW) begin sq.push_back(4); rq.push_back(1'($urandom)); end
    end else if (o == RT) begin
      if (f == FJR) begin
        sq.push_back(12); rq.push_back(1'($urandom));
      end else begin
        sq.push_back(6); rq.push_back(1'($urandom));
        sq.push_back(7); rq.push_back(1'($urandom));
      end
    end else if (o == BEQ) begin
      sq.push_back(8); rq.push_back(1'($urandom));
    end else if (o == J || o == JAL) begin
      sq.push_back(9); rq.push_back(1'($urandom));
    end else if (im && is_imm(o)) begin
      sq.push_back(10); rq.push_back(1'($urandom));
      sq.push_back(11); rq.push_back(1'($urandom));
    end
    for (int i = 0; i < sq.size(); i++) begin
      rdy = rq[i];
      @(negedge clk);
      eff = we ? rq[i] : 1'b1;
      checks++;
      if (st !== 4'(sq[i])) begin
        failures++;
        $display("FAIL state dut%0d op=%b fn=%b cyc=%0d got=%0d exp=%0d",
                 sel, o, f, i, st, sq[i]);
      end
      checks++;
      if (obs !== exp_out(sq[i], eff, o, im)) begin
        failures++;
        $display("FAIL outputs dut%0d op=%b fn=%b st=%0d got=%b exp=%b",
                 sel, o, f, sq[i], obs, exp_out(sq[i], eff, o, im));
      end
      checks++;
      if (obs[15] === 1'b1 && obs[14] === 1'b1) begin
        failures++;
        $display("FAIL rd_wr_excl dut%0d st=%0d got=11 exp=not both", sel, sq[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset(input logic s);
    sel = s; rst = 1'b1; op = LW; fn = 6'd0; rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs !== 19'd0 || st !== 4'd0) begin
        failures++;
        $display("FAIL reset_hold dut%0d got=%b/%0d exp=0/0", s, obs, st);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (st !== 4'd0 || obs[15] !== 1'b1) begin
      failures++;
      $display("FAIL reset_release dut%0d state=%0d mem_read=%b exp=0/1", s, st, obs[15]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lw;      run_instr(LW, 6'd0, 0); run_instr(LW, 6'd5, 2); endtask
  task automatic test_sw_wait; run_instr(SW, 6'd0, 3); endtask
  task automatic test_rtype_jr;
    run_instr(RT, 6'b100000, 0);
    run_instr(RT, FJR, 0);
  endtask
  task automatic test_jal_beq;
    run_instr(JAL, 6'd0, 0); run_instr(BEQ, 6'd0, 0); run_instr(J, 6'd0, 0);
  endtask
  task automatic test_imm;     run_instr(ADDI, 6'd0, 0); run_instr(ANDI, 6'd0, 0);
                               run_instr(ORI, 6'd0, 0); endtask
  task automatic test_illegal_dut0; run_instr(6'b111111, 6'd0, 0); endtask
  task automatic test_illegal_dut1;
    run_instr(ADDI, 6'd0, 0); run_instr(ORI, 6'd0, 0); run_instr(LW, 6'd0, 0);
    run_instr(SW, 6'd0, 0);
  endtask

  task automatic test_reset_in_memrd;
    op = LW; fn = 6'd0; rdy = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (st !== 4'd3) begin
      failures++;
      $display("FAIL midreset_memrd got=%0d exp=3", st);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== 19'd0) begin
      failures++;
      $display("FAIL midreset_hold got=%b exp=0", obs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (st !== 4'd0 || obs[10] !== 1'b0) begin
      failures++;
      $display("FAIL midreset_after state=%0d reg_write=%b exp=0/0", st, obs[10]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random(input int n);
    logic [5:0] tbl [10];
    logic [5:0] o, f;
    tbl = '{LW, SW, RT, RT, BEQ, J, JAL, ADDI, ANDI, ORI};
    for (int k = 0; k < n; k++) begin
      o = ($urandom_range(0, 4) == 0) ? 6'($urandom) : tbl[$urandom_range(0, 9)];
      f = ($urandom_range(0, 3) == 0) ? FJR : 6'($urandom);
      run_instr(o, f, -1);
    end
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; op = 6'd0; fn = 6'd0; rdy = 1'b0;
    test_reset(1'b0);
    test_lw();
    test_sw_wait();
    test_rtype_jr();
    test_jal_beq();
    test_imm();
    test_illegal_dut0();
    test_reset_in_memrd();
    test_random(40);
    test_reset(1'b1);
    test_illegal_dut1();
    test_random(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
